cpu_core_p: RTL
===============

# cpu_core_p

Parametrised successor to the nibble CPU in the tinysoc. It keeps the same instruction classes: ALU, load, store, immediate, jump, conditional jump. Data width and register-file depth are configurable, and two instructions are added: HALT and NOP. Data memory sits behind a req/ack handshake, so the core stalls on slow memory. It sits between the instruction ROM (combinational read) and the data memory / GPO of the SoC top.

## Interface
Parameters:
- `DW`, 4: data width; also the immediate/address field width; must be ≥4.
- `RA`, 3: register address bits; register file has 2^RA entries.
- `IA`, 3: instruction address (PC) bits; must be ≤`DW`.
- `GPO_ADDR`, 8: store address that targets the `gpo` register instead of memory.
- Derived: `IW = 3 + 3*RA + DW`, which is 16 with the defaults.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: run enable, sampled at instruction boundaries.
- `i_addr`, out, IA: instruction address; equals `pc`.
- `instr`, in, IW: instruction word for `i_addr`, valid in the same cycle.
- `d_req`, out, 1: data request, registered.
- `d_we`, out, 1: 1 for store, 0 for load; valid while `d_req`.
- `d_addr`, out, DW: data address; valid while `d_req`.
- `d_wdata`, out, DW: store data; valid while `d_req`.
- `d_rdata`, in, DW: load data; sampled in the `d_ack` cycle.
- `d_ack`, in, 1: transfer complete; ignored while `d_req`=0.
- `gpo`, out, DW: general-purpose output register.
- `halted`, out, 1: high in the HALT state.

## Operation
Instruction fields, MSB first:
- `type[IW-1:IW-3]`
- `rd` (RA bits)
- `rs2` (RA bits)
- `rs1` (RA bits)
- `imm[DW-1:0]`

Instruction types:
- 000 ALU: `rd` ← `rs1` op `rs2`, with op = `imm[2:0]`:
  - ADD; AND; OR; XOR; NOT (`rs1` only).
  - EQ and LT: result is 1 or 0 zero-extended to DW; LT is unsigned.
  - LSH: `rs1` shifted left by 1, LSB filled with 0.
  - All arithmetic is modulo 2^DW.
- 001 LOAD: `rd` ← mem[`imm`].
- 010 STORE: mem[`imm`] ← `rs1`. If `imm`==`GPO_ADDR`, `gpo` ← `rs1` instead and no request is issued.
- 011 IMM: `rd` ← `imm`.
- 100 JUMP: `pc` ← `rs1[IA-1:0]`.
- 101 CJUMP: if `rs1[0]`, `pc` ← `imm[IA-1:0]`, else `pc`+1.
- 110 HALT: enter HALT.
- 111 NOP: `pc`+1.

Register file:
- 2^RA×DW, two combinational read ports, one synchronous write port.
- All entries clear to 0 on reset.
- Every register, including r0, is writable.

PC: increments modulo 2^IA, so `pc`=2^IA−1 wraps to 0.

FSM states:
- IDLE:
  - `en`=1 → EXEC.
  - Otherwise stay; nothing is executed.
- EXEC (executes `instr` at `pc`):
  - `en`=0 → IDLE; nothing is executed and state is unchanged.
  - LOAD, or STORE to non-GPO: register `d_req`=1 with `d_we`/`d_addr`/`d_wdata` → MEM; `pc` is held.
  - HALT → HALT.
  - Otherwise: retire (register write, PC update), stay in EXEC.
- MEM:
  - Hold `d_req`/`d_we`/`d_addr`/`d_wdata` stable until `d_ack`.
  - On `d_ack`:
    - `d_req` ← 0.
    - LOAD writes `rd` ← `d_rdata`.
    - `pc`+1.
    - Next state is EXEC if `en`=1, else IDLE.
  - `en` dropping during MEM does not abort the transfer.
- HALT: stays until reset; `halted`=1. `gpo` and the register file hold their values.

## Timing
- Reset values:
  - state IDLE; `pc`=0.
  - `d_req`=0, `d_we`=0, `d_addr`=0, `d_wdata`=0.
  - `gpo`=0; `halted`=0; all registers 0.
- `rst_n` low in any state, including MEM with `d_req` high, takes effect on the next edge and drops `d_req`.
- ALU, IMM, JUMP, CJUMP, NOP and GPO-store each take 1 cycle in EXEC; the result is visible in the register file and `pc` after that edge.
- LOAD/STORE take 1 EXEC cycle plus N MEM cycles, where N ≥1 counts up to and including the `d_ack` cycle. With ack in the first MEM cycle, the total is 2 cycles.
- `d_ack` in the same cycle that `d_req` first rises is not possible, because `d_req` is registered in EXEC and first seen in MEM.
- The first instruction executes in the cycle after `en` is seen high in IDLE.
- A write to `rd` followed by a read of it in the next instruction returns the new value; there is no pipeline hazard.

## Configuration
- Macro: `CPU_SUB_EN`.
- Defined: ALU op 000 with `imm[3]`=1 computes `rs1`−`rs2` modulo 2^DW.
- Undefined: `imm[3]` is ignored and op 000 is always ADD.

## Test plan
- Reset, then `en`=1; program `IMM r1,5`; `IMM r2,3`; ALU ADD r3=r1+r2; STORE r3→8; HALT → `gpo`=8, `halted`=1 after 5 execute cycles, `d_req` never high.
- STORE r1 (=5) to address 2 with `d_ack` delayed 3 cycles, then LOAD r4 from 2 → `d_req` is held 3 cycles with `d_addr`=2, `d_we`=1, `d_wdata`=5; the load returns 5 into r4; `pc` advances only on ack.
- CJUMP with r1=1 to addr 6 → `pc`=6; with r1=0 → `pc`+1. JUMP via r2=7 → `pc`=7; NOP at 7 → `pc` wraps to 0.
- ALU edge cases with DW=4: 15+1=0; LT 3<5=1; EQ 5,5=1; NOT 0=15; LSH 9=2. With `CPU_SUB_EN`: 3−5=14.
- Drop `en` during a stalled LOAD → the transfer completes on `d_ack`, the core enters IDLE, and `pc` is frozen until `en` rises again.
- Assert `rst_n`=0 in MEM → the next edge shows `d_req`=0, `pc`=0, all registers 0, `gpo`=0, state IDLE.

Source files
------------

// File: rtl/cpu_core_p.sv
// Parametrised multi-cycle CPU core: ALU/load/store/imm/jump/cjump/halt/nop, stalls on data memory req/ack.
// Optional: define CPU_SUB_EN to make ALU op 000 with imm[3]=1 compute rs1-rs2.
module cpu_core_p #(
  parameter int DW       = 4,
  parameter int RA       = 3,
  parameter int IA       = 3,
  parameter int GPO_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [IA-1:0]          i_addr,
  input  logic [3+3*RA+DW-1:0]   instr,
  output logic                   d_req,
  output logic                   d_we,
  output logic [DW-1:0]          d_addr,
  output logic [DW-1:0]          d_wdata,
  input  logic [DW-1:0]          d_rdata,
  input  logic                   d_ack,
  output logic [DW-1:0]          gpo,
  output logic                   halted
);
  localparam int IW   = 3 + 3*RA + DW;
  localparam int NREG = 1 << RA;
  localparam logic [DW-1:0] GPO_A = DW'(GPO_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [2:0] {T_ALU, T_LOAD, T_STORE, T_IMM, T_JUMP, T_CJUMP, T_HALT, T_NOP} itype_t;

  state_t                   state, nstate;
  logic [IA-1:0]            pc, pc_nxt;
  logic [NREG-1:0][DW-1:0]  rf;
  logic [RA-1:0]            mem_rd;

  itype_t        typ;
  logic [RA-1:0] rd, rs2, rs1;
  logic [DW-1:0] imm, rs1v, rs2v, alu;

  assign typ    = itype_t'(instr[IW-1 -: 3]);
  assign rd     = instr[DW+3*RA-1 -: RA];
  assign rs2    = instr[DW+2*RA-1 -: RA];
  assign rs1    = instr[DW+RA-1 -: RA];
  assign imm    = instr[DW-1:0];
  assign rs1v   = rf[rs1];
  assign rs2v   = rf[rs2];
  assign i_addr = pc;
  assign halted = (state == S_HALT);

  always_comb begin
    alu = '0;
    case (imm[2:0])
`ifdef CPU_SUB_EN
      3'd0: alu = imm[3] ? (rs1v - rs2v) : (rs1v + rs2v);
`else
      3'd0: alu = rs1v + rs2v;
`endif
      3'd1: alu = rs1v & rs2v;
      3'd2: alu = rs1v | rs2v;
      3'd3: alu = rs1v ^ rs2v;
      3'd4: alu = ~rs1v;
      3'd5: alu = {{(DW-1){1'b0}}, rs1v == rs2v};
      3'd6: alu = {{(DW-1){1'b0}}, rs1v <  rs2v};
      3'd7: alu = {rs1v[DW-2:0], 1'b0};
      default: alu = '0;
    endcase
  end

  // Control: decides next state plus the single-cycle side effects of this cycle.
  logic          pc_we, rf_we, gpo_we, mem_go, mem_done;
  logic [RA-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  always_comb begin
    nstate   = state;
    pc_we    = 1'b0;
    pc_nxt   = pc + IA'(1);
    rf_we    = 1'b0;
    rf_wa    = rd;
    rf_wd    = alu;
    gpo_we   = 1'b0;
    mem_go   = 1'b0;
    mem_done = 1'b0;
    case (state)
      S_IDLE: if (en) nstate = S_EXEC;
      S_EXEC: begin
        if (!en) begin
          nstate = S_IDLE;
        end else begin
          case (typ)
            T_ALU:   begin rf_we = 1'b1; pc_we = 1'b1; end
            T_LOAD:  begin mem_go = 1'b1; nstate = S_MEM; end
            T_STORE: begin
              if (imm == GPO_A) begin
                gpo_we = 1'b1;
                pc_we  = 1'b1;
              end else begin
                mem_go = 1'b1;
                nstate = S_MEM;
              end
            end
            T_IMM:   begin rf_we = 1'b1; rf_wd = imm; pc_we = 1'b1; end
            T_JUMP:  begin pc_we = 1'b1; pc_nxt = rs1v[IA-1:0]; end
            T_CJUMP: begin
              pc_we = 1'b1;
              if (rs1v[0]) pc_nxt = imm[IA-1:0];
            end
            T_HALT:  nstate = S_HALT;
            T_NOP:   pc_we = 1'b1;
            default: pc_we = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        // en is not consulted until the transfer completes.
        if (d_ack) begin
          mem_done = 1'b1;
          pc_we    = 1'b1;
          rf_we    = !d_we;
          rf_wa    = mem_rd;
          rf_wd    = d_rdata;
          nstate   = en ? S_EXEC : S_IDLE;
        end
      end
      S_HALT: nstate = S_HALT;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      rf      <= '0;
      gpo     <= '0;
      d_req   <= 1'b0;
      d_we    <= 1'b0;
      d_addr  <= '0;
      d_wdata <= '0;
      mem_rd  <= '0;
    end else begin
      if (pc_we)  pc        <= pc_nxt;
      if (rf_we)  rf[rf_wa] <= rf_wd;
      if (gpo_we) gpo       <= rs1v;
      if (mem_go) begin
        d_req   <= 1'b1;
        d_we    <= (typ == T_STORE);
        d_addr  <= imm;
        d_wdata <= rs1v;
        mem_rd  <= rd;
      end else if (mem_done) begin
        d_req   <= 1'b0;
      end
    end
  end
endmodule
